// File: rtl/ebc_pkg.sv
// ebc_pkg: shared definitions for the ECB decrypt-cell serializer.
//   state_t          - serializer states (no key / waiting for block / shifting)
//   EBC_WIDTH        - default block and key width in bits
//   EBC_BLK_CNT_W    - default width of the completed-block counter
package ebc_pkg;

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam int EBC_WIDTH     = 8;
    localparam int EBC_BLK_CNT_W = 16;

endpackage

// File: rtl/ebc_dec_serializer_shift_reg.sv
// ebc_shift_reg: WIDTH-bit parallel-load, shift-left register with MSB output.
//   clk        - clock, rising edge
//   rst        - synchronous active-high clear
//   load_i     - load load_val_i (takes priority over shift)
//   load_val_i - parallel load value
//   shift_i    - shift left by one, zero fill
//   msb_o      - current most significant bit
module ebc_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/ebc_dec_serializer.sv
// ebc_dec_serializer: feeds the 1-bit ECB XOR decrypt cell. Accepts WIDTH-bit
// ciphertext blocks over valid/ready and shifts each out MSB-first together
// with the matching bit of the held key, framed by bit_valid/bit_last.
//   clk, rst            - clock and synchronous active-high reset
//   key_load, key_in    - key load strobe and value
//   ct_valid/ct_ready   - ciphertext block handshake, ct_in block data
//   ct_bit, k_bit       - current ciphertext / key bit
//   bit_valid/bit_ready - bit handshake, bit_last marks the block LSB
//   key_loaded          - a key is held since reset
//   key_err             - pulse: key_load ignored while shifting
//   blk_count           - completed blocks, wraps silently
module ebc_dec_serializer
    import ebc_pkg::*;
#(
    parameter int WIDTH     = EBC_WIDTH,
    parameter int BLK_CNT_W = EBC_BLK_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_load,
    input  logic [WIDTH-1:0]     key_in,
    input  logic                 ct_valid,
    output logic                 ct_ready,
    input  logic [WIDTH-1:0]     ct_in,
    output logic                 ct_bit,
    output logic                 k_bit,
    output logic                 bit_valid,
    input  logic                 bit_ready,
    output logic                 bit_last,
    output logic                 key_loaded,
    output logic                 key_err,
    output logic [BLK_CNT_W-1:0] blk_count
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     key_q, key_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLK_CNT_W-1:0] blk_count_q, blk_count_d;
    logic                 key_loaded_q, key_loaded_d;
    logic                 key_err_q, key_err_d;

    logic valid, last, hs, ready, accept, shift_en;
    logic ct_msb, k_msb;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        idx_d        = idx_q;
        blk_count_d  = blk_count_q;
        key_loaded_d = key_loaded_q;
        ready        = 1'b0;
        shift_en     = 1'b0;
        valid        = (state_q == S_SHIFT);
        last         = valid && (idx_q == IDX_LAST);
        hs           = valid && bit_ready;
        // The in-flight block keeps its captured key; a reload attempt is only flagged.
        key_err_d    = key_load && valid;

        case (state_q)
            S_NOKEY: begin
                if (key_load) begin
                    key_d        = key_in;
                    key_loaded_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A key reload wins over a block offered in the same cycle.
                ready = !key_load;
                if (key_load) begin
                    key_d = key_in;
                end
            end
            S_SHIFT: begin
                if (hs) begin
                    if (last) begin
                        // Open the input during the final handshake so blocks stream without a bubble.
                        ready       = 1'b1;
                        blk_count_d = blk_count_q + BLK_CNT_W'(1);
                        state_d     = S_WAIT;
                    end else begin
                        shift_en = 1'b1;
                        idx_d    = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_NOKEY;
        endcase

        accept = ct_valid && ready;
        if (accept) begin
            state_d = S_SHIFT;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_NOKEY;
            key_q        <= '0;
            idx_q        <= '0;
            blk_count_q  <= '0;
            key_loaded_q <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            idx_q        <= idx_d;
            blk_count_q  <= blk_count_d;
            key_loaded_q <= key_loaded_d;
            key_err_q    <= key_err_d;
        end
    end

    ebc_shift_reg #(.WIDTH(WIDTH)) u_ct_sr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (ct_in),
        .shift_i    (shift_en),
        .msb_o      (ct_msb)
    );

    ebc_shift_reg #(.WIDTH(WIDTH)) u_k_sr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (key_q),
        .shift_i    (shift_en),
        .msb_o      (k_msb)
    );

    // Bits are forced low outside S_SHIFT so idle outputs never leak stale data.
    assign ct_bit     = valid && ct_msb;
    assign k_bit      = valid && k_msb;
    assign bit_valid  = valid;
    assign bit_last   = last;
    assign ct_ready   = ready;
    assign key_loaded = key_loaded_q;
    assign key_err    = key_err_q;
    assign blk_count  = blk_count_q;

endmodule

// File: tb/tb_ebc_dec_serializer.sv
module tb_ebc_dec_serializer;

    localparam int W   = 8;
    localparam int BCW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           key_load = 1'b0;
    logic [W-1:0]   key_in = '0;
    logic           ct_valid = 1'b0;
    logic           ct_ready;
    logic [W-1:0]   ct_in = '0;
    logic           ct_bit, k_bit, bit_valid, bit_last, key_loaded, key_err;
    logic           bit_ready = 1'b0;
    logic [BCW-1:0] blk_count;

    ebc_dec_serializer #(.WIDTH(W), .BLK_CNT_W(BCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .ct_in      (ct_in),
        .ct_bit     (ct_bit),
        .k_bit      (k_bit),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_last   (bit_last),
        .key_loaded (key_loaded),
        .key_err    (key_err),
        .blk_count  (blk_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: whether a key is held, the key, and the block in flight
    // as the captured ciphertext/key words plus how many bits have been emitted.
    bit           m_ok = 0, m_key_ok = 0, m_busy = 0, m_err = 0;
    logic [W-1:0] m_key = '0, m_ct = '0, m_k = '0;
    int           m_pos = 0, m_cnt = 0;

    // Handshake capture from the DUT side.
    int          hs_total = 0, last_total = 0, err_total = 0;
    logic [63:0] hs_ct = '0, hs_k = '0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        if (!m_key_ok) return 1'b0;
        if (m_busy) return bit_ready && (m_pos == W - 1);
        return !key_load;
    endfunction

    // One clock cycle: inputs were driven at the falling edge; compare, record
    // handshakes, advance the model with those inputs, wait for the next falling edge.
    task automatic cyc();
        bit rdy, hs, lastb;
        #2;
        if (m_ok) begin
            check("ct_ready",   ct_ready,   exp_ready());
            check("bit_valid",  bit_valid,  m_busy);
            check("bit_last",   bit_last,   m_busy && (m_pos == W - 1));
            check("key_loaded", key_loaded, m_key_ok);
            check("key_err",    key_err,    m_err);
            check("blk_count",  blk_count,  m_cnt);
            if (m_busy) begin
                check("ct_bit", ct_bit, m_ct[W-1-m_pos]);
                check("k_bit",  k_bit,  m_k[W-1-m_pos]);
            end
        end
        if (!rst && bit_valid && bit_ready) begin
            hs_total++;
            hs_ct = {hs_ct[62:0], ct_bit};
            hs_k  = {hs_k[62:0], k_bit};
            if (bit_last) last_total++;
        end
        if (!rst && key_err) err_total++;

        if (rst) begin
            m_ok = 1; m_key_ok = 0; m_busy = 0; m_err = 0;
            m_key = '0; m_pos = 0; m_cnt = 0;
        end else if (m_ok) begin
            rdy   = exp_ready();
            hs    = m_busy && bit_ready;
            lastb = hs && (m_pos == W - 1);
            m_err = key_load && m_busy;
            if (!m_busy && key_load) begin
                m_key    = key_in;
                m_key_ok = 1;
            end
            if (lastb) begin
                m_cnt  = (m_cnt + 1) % (1 << BCW);
                m_busy = 0;
            end else if (hs) begin
                m_pos++;
            end
            if (ct_valid && rdy) begin
                m_busy = 1;
                m_ct   = ct_in;
                m_k    = m_key;
                m_pos  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic load_key(input logic [W-1:0] k);
        key_load = 1'b1;
        key_in   = k;
        cyc();
        key_load = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] c);
        int  n = 0;
        bit  acc = 0;
        ct_valid = 1'b1;
        ct_in    = c;
        while (!acc && n < 100) begin
            #1;
            acc = ct_ready;
            cyc();
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        ct_valid = 1'b0;
    endtask

    // mode 0: bit_ready=1; 1: pattern 1,0,0; 2: random
    task automatic wait_hs(input int n, input int mode);
        int base = hs_total;
        int t = 0;
        while (hs_total < base + n && t < 400) begin
            case (mode)
                0: bit_ready = 1'b1;
                1: bit_ready = (t % 3 == 0);
                default: bit_ready = 1'($urandom_range(0, 1));
            endcase
            cyc();
            t++;
        end
        if (hs_total < base + n) check("hs_timeout", hs_total - base, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lbase, ebase, bad;
        @(negedge clk);
        repeat (3) cyc();

        // Reset state
        check("rst_bit_valid",  bit_valid,  0);
        check("rst_ct_ready",   ct_ready,   0);
        check("rst_key_loaded", key_loaded, 0);
        check("rst_blk_count",  blk_count,  0);
        check("rst_bits",       {ct_bit, k_bit, bit_last, key_err}, 0);
        rst = 1'b0;

        // No key: block offered for 20 cycles is never taken
        ct_valid = 1'b1;
        ct_in    = 8'h5A;
        bit_ready = 1'b1;
        bad = 0;
        repeat (20) begin
            #1;
            if (ct_ready || bit_valid) bad++;
            cyc();
        end
        check("nokey_ready_cycles", bad, 0);
        ct_valid = 1'b0;

        // Basic block: key A5, ct 3C -> pt 99
        load_key(8'hA5);
        lbase = last_total;
        base  = hs_total;
        send(8'h3C);
        wait_hs(8, 0);
        check("basic_hs",     hs_total - base, 8);
        check("basic_ct",     hs_ct[7:0], 8'h3C);
        check("basic_k",      hs_k[7:0],  8'hA5);
        check("basic_pt",     hs_ct[7:0] ^ hs_k[7:0], 8'h99);
        check("basic_last",   last_total - lbase, 1);
        check("basic_count",  blk_count, 1);

        // Back-to-back: 00 then FF with ct_valid held
        ct_valid = 1'b1;
        ct_in    = 8'h00;
        bit_ready = 1'b1;
        cyc();
        ct_in = 8'hFF;
        base  = hs_total;
        repeat (8) cyc();
        ct_valid = 1'b0;
        repeat (8) cyc();
        check("b2b_hs_in_16",  hs_total - base, 16);
        check("b2b_ct",        hs_ct[15:0], 16'h00FF);
        check("b2b_count",     blk_count, 3);

        // Backpressure 1,0,0,1,...
        base = hs_total;
        send(8'h3C);
        wait_hs(8, 1);
        bit_ready = 1'b1;
        repeat (4) cyc();
        check("bp_hs",    hs_total - base, 8);
        check("bp_ct",    hs_ct[7:0], 8'h3C);
        check("bp_k",     hs_k[7:0],  8'hA5);
        check("bp_count", blk_count, 0);

        // Key load during a block is rejected
        ebase = err_total;
        send(8'h3C);
        wait_hs(3, 0);
        key_load = 1'b1;
        key_in   = 8'hFF;
        cyc();
        key_load = 1'b0;
        wait_hs(4, 0);
        check("kchg_err_pulses", err_total - ebase, 1);
        check("kchg_k",          hs_k[7:0], 8'hA5);
        // Key load while waiting takes effect
        load_key(8'hFF);
        send(8'h00);
        wait_hs(8, 0);
        check("kwait_k",  hs_k[7:0],  8'hFF);
        check("kwait_ct", hs_ct[7:0], 8'h00);

        // Reset in the middle of a block
        lbase = last_total;
        send(8'hC3);
        wait_hs(4, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_valid",      bit_valid,  0);
        check("mid_rst_key_loaded", key_loaded, 0);
        check("mid_rst_count",      blk_count,  0);
        check("mid_rst_bits",       {ct_bit, k_bit, bit_last, ct_ready}, 0);
        check("mid_rst_no_last",    last_total - lbase, 0);

        // Counter wrap: 5 random blocks with random backpressure
        load_key(8'($urandom));
        repeat (5) begin
            send(8'($urandom));
            wait_hs(8, 2);
        end
        check("wrap_count", blk_count, 1);

        // Free-running random traffic checked by the model every cycle
        repeat (1500) begin
            ct_valid  = 1'($urandom_range(0, 1));
            ct_in     = 8'($urandom);
            bit_ready = 1'($urandom_range(0, 1));
            key_load  = ($urandom_range(0, 15) == 0);
            key_in    = 8'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; key_load = 1'b0; ct_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
